// File: rtl/paint_pkg.sv
// ============================================================================
// Module : paint_pkg
// Brief  : Shared types and background-gradient constants for the brush mapper.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package paint_pkg;

    typedef enum logic [1:0] {
        OFF    = 2'b00,
        FILLED = 2'b01,
        RING   = 2'b10,
        RSVD   = 2'b11
    } brush_mode_e;

    localparam int RGB_COMP_W = 8;

    typedef struct packed {
        logic [RGB_COMP_W-1:0] r;
        logic [RGB_COMP_W-1:0] g;
        logic [RGB_COMP_W-1:0] b;
    } rgb_t;

    localparam logic [5:0] BG_BLUE_BASE  = 6'h3F;
    localparam int         BG_RED_SHIFT  = 3;
    localparam int         BG_BLUE_SHIFT = 4;

endpackage

`default_nettype wire

// File: rtl/brush_hit.sv
// ============================================================================
// Module : brush_hit
// Brief  : Three-stage distance/compare pipeline for one circular brush.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module brush_hit
    import paint_pkg::*;
#(
    parameter int COORD_W = 10,
    parameter int COLOR_W = 8,
    parameter int RING_W  = 2
) (
    input  logic                   clk,
    input  logic                   i_valid,
    input  logic [COORD_W-1:0]     i_draw_x,
    input  logic [COORD_W-1:0]     i_draw_y,
    input  logic [COORD_W-1:0]     i_x,
    input  logic [COORD_W-1:0]     i_y,
    input  logic [COORD_W-1:0]     i_size,
    input  logic [3*COLOR_W-1:0]   i_color,
    input  logic [1:0]             i_mode,
    output logic                   o_hit,
    output logic [3*COLOR_W-1:0]   o_color
);

    localparam int SQ_W = 2 * COORD_W;
    localparam int D2_W = 2 * COORD_W + 3;

    // Stage 1: signed offsets and inner ring radius
    logic signed [COORD_W:0]   r_dx;
    logic signed [COORD_W:0]   r_dy;
    logic [COORD_W-1:0]        r_size1;
    logic [COORD_W-1:0]        r_rin1;
    brush_mode_e               r_mode1;
    logic [3*COLOR_W-1:0]      r_col1;
    logic [COORD_W-1:0]        w_rin;

    always_comb begin
        w_rin = '0;
        if (i_size > COORD_W'(RING_W))
            w_rin = i_size - COORD_W'(RING_W);
    end

    always_ff @(posedge clk) begin
        if (i_valid) begin
            r_dx    <= $signed({1'b0, i_draw_x}) - $signed({1'b0, i_x});
            r_dy    <= $signed({1'b0, i_draw_y}) - $signed({1'b0, i_y});
            r_size1 <= i_size;
            r_rin1  <= w_rin;
            r_mode1 <= brush_mode_e'(i_mode);
            r_col1  <= i_color;
        end
    end

    // Stage 2: squared distance and squared radii
    logic signed [SQ_W+1:0]    w_dxe;
    logic signed [SQ_W+1:0]    w_dye;
    logic signed [SQ_W+1:0]    w_dx2;
    logic signed [SQ_W+1:0]    w_dy2;
    logic [SQ_W-1:0]           w_s2;
    logic [SQ_W-1:0]           w_r2;
    logic [D2_W-1:0]           r_d2;
    logic [SQ_W-1:0]           r_s2;
    logic [SQ_W-1:0]           r_rin2sq;
    brush_mode_e               r_mode2;
    logic [3*COLOR_W-1:0]      r_col2;

    assign w_dxe = {{(COORD_W+1){r_dx[COORD_W]}}, r_dx};
    assign w_dye = {{(COORD_W+1){r_dy[COORD_W]}}, r_dy};
    assign w_dx2 = w_dxe * w_dxe;
    assign w_dy2 = w_dye * w_dye;
    assign w_s2  = {{COORD_W{1'b0}}, r_size1} * {{COORD_W{1'b0}}, r_size1};
    assign w_r2  = {{COORD_W{1'b0}}, r_rin1} * {{COORD_W{1'b0}}, r_rin1};

    always_ff @(posedge clk) begin
        r_d2     <= {1'b0, w_dx2} + {1'b0, w_dy2};
        r_s2     <= w_s2;
        r_rin2sq <= w_r2;
        r_mode2  <= r_mode1;
        r_col2   <= r_col1;
    end

    // Stage 3: hit test
    logic w_inside;
    logic w_hit;

    assign w_inside = (r_d2 <= {3'b000, r_s2});

    always_comb begin
        w_hit = 1'b0;
        case (r_mode2)
            FILLED:  w_hit = w_inside;
            RING:    w_hit = w_inside && ((r_rin2sq == '0) || (r_d2 > {3'b000, r_rin2sq}));
            default: w_hit = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        o_hit   <= w_hit;
        o_color <= r_col2;
    end

endmodule

`default_nettype wire

// File: rtl/brush_layer_mapper.sv
// ============================================================================
// Module : brush_layer_mapper
// Brief  : Composites prioritised circular brushes over a gradient background.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module brush_layer_mapper
    import paint_pkg::*;
#(
    parameter int NUM_BRUSH = 4,
    parameter int COORD_W   = 10,
    parameter int COLOR_W   = 8,
    parameter int RING_W    = 2
) (
    input  logic                           Clk,
    input  logic                           Reset_n,
    input  logic                           frame_start,
    input  logic [NUM_BRUSH*COORD_W-1:0]   brush_x,
    input  logic [NUM_BRUSH*COORD_W-1:0]   brush_y,
    input  logic [NUM_BRUSH*COORD_W-1:0]   brush_size,
    input  logic [NUM_BRUSH*3*COLOR_W-1:0] brush_color,
    input  logic [NUM_BRUSH*2-1:0]         brush_mode,
    input  logic [COORD_W-1:0]             DrawX,
    input  logic [COORD_W-1:0]             DrawY,
    input  logic                           pix_valid_in,
    output logic                           pix_valid_out,
    output logic [COLOR_W-1:0]             Red,
    output logic [COLOR_W-1:0]             Green,
    output logic [COLOR_W-1:0]             Blue
);

    localparam int BGX_W = COORD_W - BG_BLUE_SHIFT;
    localparam int BGY_W = COORD_W - BG_RED_SHIFT;
    localparam int PIX_W = 3 * COLOR_W;

    // Active (shadow) brush set, swapped only on frame_start
    logic [NUM_BRUSH*COORD_W-1:0]   r_bx;
    logic [NUM_BRUSH*COORD_W-1:0]   r_by;
    logic [NUM_BRUSH*COORD_W-1:0]   r_bsz;
    logic [NUM_BRUSH*PIX_W-1:0]     r_bcol;
    logic [NUM_BRUSH*2-1:0]         r_bmode;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_bx    <= '0;
            r_by    <= '0;
            r_bsz   <= '0;
            r_bcol  <= '0;
            r_bmode <= '0;
        end else if (frame_start) begin
            r_bx    <= brush_x;
            r_by    <= brush_y;
            r_bsz   <= brush_size;
            r_bcol  <= brush_color;
            r_bmode <= brush_mode;
        end
    end

    logic [NUM_BRUSH-1:0]         w_hit;
    logic [NUM_BRUSH*PIX_W-1:0]   w_col;

    genvar gi;
    for (gi = 0; gi < NUM_BRUSH; gi++) begin : g_brush
        brush_hit #(
            .COORD_W (COORD_W),
            .COLOR_W (COLOR_W),
            .RING_W  (RING_W)
        ) u_hit (
            .clk      (Clk),
            .i_valid  (pix_valid_in),
            .i_draw_x (DrawX),
            .i_draw_y (DrawY),
            .i_x      (r_bx[gi*COORD_W +: COORD_W]),
            .i_y      (r_by[gi*COORD_W +: COORD_W]),
            .i_size   (r_bsz[gi*COORD_W +: COORD_W]),
            .i_color  (r_bcol[gi*PIX_W +: PIX_W]),
            .i_mode   (r_bmode[gi*2 +: 2]),
            .o_hit    (w_hit[gi]),
            .o_color  (w_col[gi*PIX_W +: PIX_W])
        );
    end

    // Valid and background-coordinate pipeline, aligned with the brush stages
    logic             r_v1, r_v2, r_v3;
    logic [BGX_W-1:0] r_bgx1, r_bgx2, r_bgx3;
    logic [BGY_W-1:0] r_bgy1, r_bgy2, r_bgy3;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
        end else begin
            r_v1 <= pix_valid_in;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
        end
    end

    always_ff @(posedge Clk) begin
        if (pix_valid_in) begin
            r_bgx1 <= DrawX[COORD_W-1:BG_BLUE_SHIFT];
            r_bgy1 <= DrawY[COORD_W-1:BG_RED_SHIFT];
        end
        r_bgx2 <= r_bgx1;
        r_bgy2 <= r_bgy1;
        r_bgx3 <= r_bgx2;
        r_bgy3 <= r_bgy2;
    end

    logic [COLOR_W-1:0] w_bg_r;
    logic [COLOR_W-1:0] w_bg_b;
    logic [PIX_W-1:0]   w_sel;

    assign w_bg_r = {COLOR_W{1'b1}} - COLOR_W'(r_bgy3);
    assign w_bg_b = COLOR_W'(BG_BLUE_BASE) - COLOR_W'(r_bgx3);

    // Walk from highest index down so the lowest-index hit overrides
    always_comb begin
        w_sel = {w_bg_r, {COLOR_W{1'b0}}, w_bg_b};
        for (int i = NUM_BRUSH - 1; i >= 0; i--) begin
            if (w_hit[i])
                w_sel = w_col[i*PIX_W +: PIX_W];
        end
    end

    logic             r_vout;
    logic [PIX_W-1:0] r_rgb;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_vout <= 1'b0;
            r_rgb  <= '0;
        end else begin
            r_vout <= r_v3;
            if (r_v3)
                r_rgb <= w_sel;
        end
    end

    assign pix_valid_out = r_vout;
    assign Red           = r_rgb[PIX_W-1 -: COLOR_W];
    assign Green         = r_rgb[2*COLOR_W-1 -: COLOR_W];
    assign Blue          = r_rgb[COLOR_W-1:0];

endmodule

`default_nettype wire
